hilo_writeback: RTL and testbench
=================================

# hilo_writeback

Downstream writeback stage for the divider's 64-bit `{remainder, quotient}` result. It accepts results over a valid/ready handshake and buffers up to two of them in a FIFO. Each result is written onto the shared 32-bit bus as two granted beats: quotient into LO, then remainder into HI. Results flagged as divide-by-zero are dropped, and a sticky status flag is raised instead.

## Interface
- `BITS`, default 32: datapath word width. The result is `2*BITS` wide.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream has a result on `in_result`.
- `in_ready`  out  1  a FIFO slot is free.
- `in_result`  in  2*BITS  `[2*BITS-1:BITS]` is the remainder; `[BITS-1:0]` is the quotient.
- `in_div0`  in  1  the divisor for this result was zero; sampled together with `in_result`.
- `bus_req`  out  1  requesting the bus for the current beat.
- `bus_gnt`  in  1  bus granted this cycle.
- `bus_out`  out  BITS  word driven to the bus.
- `lo_en`  out  1  load strobe for the LO register.
- `hi_en`  out  1  load strobe for the HI register.
- `busy`  out  1  FIFO is non-empty or the FSM is not in IDLE.
- `div0_flag`  out  1  sticky divide-by-zero status.
- `div0_clr`  in  1  synchronous clear of `div0_flag`.

## Operation
- **FIFO**
  - Two entries of `{div0, result}`, `2*BITS+1` bits each.
  - Push when `in_valid && in_ready`.
  - `in_ready = (count != 2)`, decoded from the registered count only. A pop in the same cycle does not enable a push when the FIFO is full.
  - Pointers wrap modulo 2.
  - A simultaneous push and pop with count 1 leaves count at 1.
- **FSM states:** IDLE, LO, HI.
  - **IDLE**
    - FIFO empty: stay in IDLE.
    - FIFO non-empty and head `div0=1`: pop the entry, set `div0_flag`, stay in IDLE. No bus activity occurs.
    - FIFO non-empty and head `div0=0`: go to LO.
  - **LO**
    - `bus_req=1` and `bus_out=head[BITS-1:0]`.
    - `lo_en = bus_gnt`.
    - On `bus_gnt` go to HI; otherwise hold with `bus_out` stable.
  - **HI**
    - `bus_req=1` and `bus_out=head[2*BITS-1:BITS]`.
    - `hi_en = bus_gnt`.
    - On `bus_gnt`, pop the entry. Go to LO if another valid entry with `div0=0` remains after the pop; otherwise go to IDLE.
- **Output qualification**
  - `lo_en` and `hi_en` are combinational from state and `bus_gnt`. They are never asserted outside LO or HI.
  - `bus_gnt` is ignored in IDLE.
  - `bus_out` is 0 whenever `bus_req=0`.
- **Status flag**
  - `div0_flag` is set by a div0 pop and cleared by `div0_clr`.
  - If a set and `div0_clr` occur in the same cycle, set wins.
- **Data handling:** no arithmetic is performed on the data; words pass through bit-exact.

## Timing
- **Reset:** while `clr` is asserted, at any time including mid-transfer:
  - state is IDLE and the FIFO is emptied;
  - `in_ready=1`, `bus_req=0`, `bus_out=0`;
  - `lo_en=0`, `hi_en=0`, `busy=0`, `div0_flag=0`.
  - A partially written pair is abandoned.
- **Latency**
  - Push at edge E0 into an empty FIFO gives FSM state LO after edge E1; `bus_req` is high in cycle E1–E2.
  - With `bus_gnt` tied high: `lo_en` is high in cycle E1–E2, `hi_en` in cycle E2–E3, and the pop occurs at E3.
- **Throughput:** with `bus_gnt` tied high, one result per 2 cycles. The FSM goes HI→LO directly with no IDLE bubble.
- **Drop path:** a div0 entry occupies IDLE for 1 cycle.
- **Backpressure:** `in_ready` falls the cycle after the second push and rises the cycle after a pop.

## Test plan
- **Reset:** assert `clr` asynchronously mid-cycle → all outputs go to their reset values immediately; `in_ready=1`.
- **Single result, 7/2:** push `in_result=0x00000001_00000003` with `bus_gnt=1` → `lo_en` with `bus_out=0x00000003` one cycle after accept, then `hi_en` with `bus_out=0x00000001`, then `busy=0`.
- **Backpressure:** hold `bus_gnt=0` and offer 3 results → 2 accepted and `in_ready=0`. `bus_out` is held at the first quotient. Release grant → the third result is accepted after the first pop, and all 6 beats appear in order.
- **Divide-by-zero:** push a result with `in_div0=1`, then a normal result `0x00000000_00000005` → no `bus_req` for the first, `div0_flag=1`, then LO=5 and HI=0 written. Pulse `div0_clr` → flag goes to 0.
- **Back-to-back:** `bus_gnt=1` and 4 consecutive results → `lo_en`/`hi_en` alternate every cycle with no IDLE gap; 8 beats in 8 cycles after the first request.
- **Reset mid-transfer:** assert `clr` in state HI before the grant → no `hi_en`; the FIFO is empty afterwards, and a new push is written correctly starting from LO.

Source files
------------

// File: rtl/hilo_writeback.sv
// Writeback stage for the divider's {remainder, quotient} result: a two-entry FIFO
// feeds a granted two-beat bus transfer (quotient -> LO, remainder -> HI).
module hilo_writeback #(
    parameter int BITS = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*BITS-1:0] in_result,
    input  logic              in_div0,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [BITS-1:0]   bus_out,
    output logic              lo_en,
    output logic              hi_en,
    output logic              busy,
    output logic              div0_flag,
    input  logic              div0_clr
);

    localparam int ENTRY_W = 2*BITS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;

    logic               push;
    logic               pop;
    logic               set_div0;
    logic [ENTRY_W-1:0] head;
    logic               head_div0;
    logic               other_div0;
    logic               next_is_data;

    // Ready is decoded from the registered count only, so a pop cannot open a slot
    // for a push in the same cycle.
    assign in_ready   = (count != 2'd2);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign head_div0  = head[ENTRY_W-1];
    assign other_div0 = mem[~rd_ptr][ENTRY_W-1];

    // Entry that becomes the head once the current one retires: the second stored
    // entry if the FIFO is full, otherwise whatever is being pushed this cycle.
    assign next_is_data = (count == 2'd2) ? !other_div0 : (push && !in_div0);

    assign busy = (count != 2'd0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_div0, in_result};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        set_div0   = 1'b0;
        bus_req    = 1'b0;
        bus_out    = '0;
        lo_en      = 1'b0;
        hi_en      = 1'b0;
        case (state)
            IDLE: begin
                // Divide-by-zero results never reach the bus; they only raise the flag.
                if (count != 2'd0) begin
                    if (head_div0) begin
                        pop      = 1'b1;
                        set_div0 = 1'b1;
                    end else begin
                        state_next = LO;
                    end
                end
            end
            LO: begin
                bus_req = 1'b1;
                bus_out = head[BITS-1:0];
                lo_en   = bus_gnt;
                if (bus_gnt) begin
                    state_next = HI;
                end
            end
            HI: begin
                bus_req = 1'b1;
                bus_out = head[2*BITS-1:BITS];
                hi_en   = bus_gnt;
                if (bus_gnt) begin
                    pop        = 1'b1;
                    state_next = next_is_data ? LO : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Set has priority over the synchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div0_flag <= 1'b0;
        end else if (set_div0) begin
            div0_flag <= 1'b1;
        end else if (div0_clr) begin
            div0_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hilo_writeback.sv
// Bench for hilo_writeback: directed scenarios plus randomized traffic, all bus beats
// checked in order against a queue of expected words built from each accepted result.
module tb_hilo_writeback;

    localparam int BITS = 32;

    logic              clk;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [2*BITS-1:0] in_result;
    logic              in_div0;
    logic              bus_req;
    logic              bus_gnt;
    logic [BITS-1:0]   bus_out;
    logic              lo_en;
    logic              hi_en;
    logic              busy;
    logic              div0_flag;
    logic              div0_clr;

    hilo_writeback #(.BITS(BITS)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_div0   (in_div0),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_out   (bus_out),
        .lo_en     (lo_en),
        .hi_en     (hi_en),
        .busy      (busy),
        .div0_flag (div0_flag),
        .div0_clr  (div0_clr)
    );

    typedef struct packed {
        logic            hi;
        logic [BITS-1:0] word;
    } beat_t;

    beat_t exp_q[$];
    int    beat_cyc[$];
    logic  beat_hi[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    rand_div0 = 0;
    bit    rand_on = 0;
    beat_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted normal result produces quotient then remainder beats;
    // an accepted div0 result produces none.
    task automatic model_accept(input logic [63:0] r, input bit z);
        beat_t b;
        if (z) begin
            rand_div0++;
        end else begin
            b.hi = 1'b0; b.word = r[31:0];  exp_q.push_back(b);
            b.hi = 1'b1; b.word = r[63:32]; exp_q.push_back(b);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_one(input logic [63:0] r, input bit z);
        int t;
        t = 0;
        in_valid  = 1'b1;
        in_result = r;
        in_div0   = z;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("push_timeout", 64'd0, 64'd1);
        end else begin
            model_accept(r, z);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_div0  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_not_busy", 64'(busy), 64'd0);
    endtask

    // Monitor: every strobe must match the next expected beat.
    always @(negedge clk) begin
        if (!clr) begin
            if (!bus_req) begin
                check("bus_out_idle_zero", 64'(bus_out), 64'd0);
            end
            if (lo_en || hi_en) begin
                beat_cyc.push_back(cyc);
                beat_hi.push_back(hi_en);
                check("strobe_needs_req_gnt", 64'(bus_req && bus_gnt), 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(bus_out), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_kind", 64'({hi_en, lo_en}), mon_e.hi ? 64'd2 : 64'd1);
                    check("beat_data", 64'(bus_out), 64'(mon_e.word));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb, rc, rx;
        int gap;
        clr       = 1'b1;
        in_valid  = 1'b0;
        in_result = '0;
        in_div0   = 1'b0;
        bus_gnt   = 1'b0;
        div0_clr  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_bus_out", 64'(bus_out), 64'd0);
        check("rst_lo_en", 64'(lo_en), 64'd0);
        check("rst_hi_en", 64'(hi_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flag", 64'(div0_flag), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Single result 7/2 with grant tied high
        bus_gnt = 1'b1;
        push_one(64'h00000001_00000003, 1'b0);
        check("single_idle_after_accept", 64'(bus_req), 64'd0);
        check("single_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("single_lo_en", 64'(lo_en), 64'd1);
        check("single_lo_word", 64'(bus_out), 64'h3);
        @(posedge clk); #1;
        check("single_hi_en", 64'(hi_en), 64'd1);
        check("single_hi_word", 64'(bus_out), 64'h1);
        @(posedge clk); #1;
        check("single_done_busy", 64'(busy), 64'd0);
        drain();

        // Backpressure with grant withheld
        bus_gnt = 1'b0;
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        rc = {$urandom(), $urandom()};
        push_one(ra, 1'b0);
        push_one(rb, 1'b0);
        check("bp_ready_low", 64'(in_ready), 64'd0);
        check("bp_req", 64'(bus_req), 64'd1);
        check("bp_first_quot", 64'(bus_out), 64'(ra[31:0]));
        fork
            push_one(rc, 1'b0);
            begin
                repeat (3) begin
                    @(posedge clk); #1;
                    check("bp_hold_quot", 64'(bus_out), 64'(ra[31:0]));
                    check("bp_ready_held_low", 64'(in_ready), 64'd0);
                end
                bus_gnt = 1'b1;
                @(posedge clk); #1;
                check("bp_ready_before_pop", 64'(in_ready), 64'd0);
                check("bp_hi_beat", 64'(hi_en), 64'd1);
                @(posedge clk); #1;
                check("bp_ready_after_pop", 64'(in_ready), 64'd1);
            end
        join
        drain();

        // Divide-by-zero drop followed by a normal result
        push_one({$urandom(), $urandom()}, 1'b1);
        check("div0_no_req", 64'(bus_req), 64'd0);
        push_one(64'h00000000_00000005, 1'b0);
        check("div0_flag_set", 64'(div0_flag), 64'd1);
        check("div0_no_req_after_drop", 64'(bus_req), 64'd0);
        drain();
        check("div0_flag_sticky", 64'(div0_flag), 64'd1);
        div0_clr = 1'b1;
        @(posedge clk); #1;
        div0_clr = 1'b0;
        check("div0_flag_cleared", 64'(div0_flag), 64'd0);

        // Set wins over a simultaneous clear
        div0_clr = 1'b1;
        push_one({$urandom(), $urandom()}, 1'b1);
        @(posedge clk); #1;
        check("div0_set_wins", 64'(div0_flag), 64'd1);
        @(posedge clk); #1;
        check("div0_clr_after_set", 64'(div0_flag), 64'd0);
        div0_clr = 1'b0;

        // Back-to-back with grant tied high
        beat_cyc.delete();
        beat_hi.delete();
        for (int i = 0; i < 4; i++) begin
            push_one({$urandom(), $urandom()}, 1'b0);
        end
        drain();
        check("b2b_beat_count", 64'(beat_cyc.size()), 64'd8);
        if (beat_cyc.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                check("b2b_consecutive", 64'(beat_cyc[i] - beat_cyc[0]), 64'(i));
                check("b2b_alternate", 64'(beat_hi[i]), 64'(i % 2));
            end
        end

        // Reset in HI before the grant
        bus_gnt = 1'b0;
        rx = {$urandom(), $urandom()};
        push_one(rx, 1'b0);
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        check("mid_in_hi_req", 64'(bus_req), 64'd1);
        check("mid_in_hi_word", 64'(bus_out), 64'(rx[63:32]));
        #2;
        clr = 1'b1;
        exp_q.delete();
        bus_gnt = 1'b1;
        #1;
        check("mid_rst_hi_en", 64'(hi_en), 64'd0);
        check("mid_rst_req", 64'(bus_req), 64'd0);
        check("mid_rst_bus_out", 64'(bus_out), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_fifo_empty", 64'(busy), 64'd0);
        push_one({$urandom(), $urandom()}, 1'b0);
        @(posedge clk); #1;
        check("mid_rst_restart_lo", 64'(lo_en), 64'd1);
        drain();

        // Randomized traffic and grants
        rand_div0 = 0;
        check("rand_flag_start", 64'(div0_flag), 64'd0);
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                    push_one({$urandom(), $urandom()}, ($urandom_range(0, 5) == 0) || (i == 7));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    bus_gnt = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus_gnt = 1'b1;
        drain();
        check("rand_flag_end", 64'(div0_flag), 64'(rand_div0 > 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
